// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder.
// A request is accepted in IDLE, the response appears LATENCY cycles later
// and is held until the requester takes it.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned requests.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. valid, once raised, holds with its payload stable until that edge.
// ready never depends combinationally on the matching valid.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbgState
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] LATLOAD = 4'(LATENCY - 1);

    // Catch illegal parameterisations at elaboration time.
    generate
        if (DEPTH < 16 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
            $error("dmem_responder: DEPTH must be a power of two in 16..65536");
        end
        if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT       state;
    logic [3:0]  cnt;
    logic        rspLoadQ;
    logic        rspErrQ;
    logic [31:0] rdCapture;
    logic [31:0] mem [DEPTH];

    logic [AW-1:0] wordIdx;
    logic          misaligned;
    logic          accept;
    logic          doWrite;
    logic          doRead;

    // Higher address bits are dropped, so addresses wrap modulo DEPTH*4.
    assign wordIdx = req_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |req_addr[1:0];
    assign rsp_err    = rsp_valid & rspErrQ;
    logic unusedBits;
    assign unusedBits = ^req_addr[31:AW+2];
`else
    assign misaligned = 1'b0;
    assign rsp_err    = 1'b0;
    logic unusedBits;
    assign unusedBits = ^{req_addr[31:AW+2], req_addr[1:0], rspErrQ};
`endif

    // req_ready is a register that is 1 only in IDLE, so this is the accept edge.
    assign accept  = req_valid & req_ready;
    assign doWrite = accept & req_we & ~misaligned;
    assign doRead  = accept & ~req_we & ~misaligned;

    // Memory array: byte-lane stores and load capture, both at the accept edge; never reset.
    always_ff @(posedge clk) begin
        if (doRead) begin
            rdCapture <= mem[wordIdx];
        end
        if (doWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[wordIdx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM: IDLE accepts, WAIT counts down the latency, RESP holds the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rspLoadQ  <= 1'b0;
            rspErrQ   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        rspLoadQ  <= ~req_we & ~misaligned;
                        rspErrQ   <= misaligned;
                        cnt       <= LATLOAD;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        // First edge after reset release raises ready here.
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        state     <= RESP;
                        cnt       <= 4'd0;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        rspLoadQ  <= 1'b0;
                        rspErrQ   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 4'd0;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    rspLoadQ  <= 1'b0;
                    rspErrQ   <= 1'b0;
                end
            endcase
        end
    end

    // Load data is visible only while a load response is valid; stores and errors read 0.
    assign rsp_rdata = (rsp_valid && rspLoadQ) ? rdCapture : 32'd0;
    assign dbgState  = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder (DEPTH=1024, LATENCY=2).
// Directed transactions with literal expectations plus a transaction-level
// model checked against the DUT on every falling edge.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  dbgState;

    int errCount   = 0;
    int checkCount = 0;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbgState(dbgState)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] modelMem [int unsigned];
    logic [31:0] exp_q[$];
    logic        err_q[$];
    bit pend     = 1'b0;
    int cyc      = 0;
    int dueCyc   = 0;
    int sinceRst = 0;

    function automatic bit mReady();
        return !pend && sinceRst >= 1;
    endfunction

    function automatic bit mValid();
        return pend && cyc >= dueCyc;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                pend     = 1'b0;
                sinceRst = 0;
                exp_q.delete();
                err_q.delete();
            end else begin
                if (mValid() && rsp_ready) begin
                    pend = 1'b0;
                    void'(exp_q.pop_front());
                    void'(err_q.pop_front());
                end else if (mReady() && req_valid) begin
                    int unsigned key;
                    bit          mis;
                    logic [31:0] w;
                    key = (req_addr >> 2) % DEPTH;
                    mis = ALIGN && (req_addr % 4 != 0);
                    w   = modelMem.exists(key) ? modelMem[key] : 32'd0;
                    if (mis) begin
                        exp_q.push_back(32'd0);
                    end else if (req_we) begin
                        for (int b = 0; b < 4; b++)
                            if (req_be[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
                        modelMem[key] = w;
                        exp_q.push_back(32'd0);
                    end else begin
                        exp_q.push_back(w);
                    end
                    err_q.push_back(mis);
                    pend   = 1'b1;
                    dueCyc = cyc + LAT;
                end
                cyc++;
                if (sinceRst < 1000000) sinceRst++;
            end
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("cmp_req_ready", {31'd0, req_ready}, {31'd0, mReady()});
                chk("cmp_rsp_valid", {31'd0, rsp_valid}, {31'd0, mValid()});
                if (mValid() && exp_q.size() > 0) begin
                    chk("cmp_rsp_rdata", rsp_rdata, exp_q[0]);
                    chk("cmp_rsp_err", {31'd0, rsp_err}, {31'd0, err_q[0]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present a request and return at the first falling edge after acceptance.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
    endtask

    task automatic doReq(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int hold,
                         input logic [31:0] expData, input logic expErr);
        int n;
        issue(we, addr, wdata, be);
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_latency"}, n, LAT);
            chk({tag, "_rdata"}, rsp_rdata, expData);
            chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, expErr});
            repeat (hold) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
                chk({tag, "_hold_rdata"}, rsp_rdata, expData);
                chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
            chk({tag, "_valid_after"}, {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        #2 reset = 1'b1;
        #1 chk("rel_req_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("rel_req_ready_high", {31'd0, req_ready}, 32'd1);
        chk("rel_state_idle", {30'd0, dbgState}, 32'd0);

        // Store then load
        doReq("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
        doReq("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);

        // Byte-lane merge
        doReq("st20", 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, 1'b0);
        doReq("st20b", 1'b1, 32'h20, 32'h000000AA, 4'h1, 0, 32'h0, 1'b0);
        doReq("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h112233AA, 1'b0);
        doReq("st20u", 1'b1, 32'h20, 32'h55667788, 4'hC, 0, 32'h0, 1'b0);
        doReq("ld20u", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h556633AA, 1'b0);

        // Zero byte-enable store is a no-op that still responds
        doReq("stbe0", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0);
        doReq("ldbe0", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h556633AA, 1'b0);

        // Backpressure on a load response
        doReq("ldbp", 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEADBEEF, 1'b0);

        // Wrap-around at DEPTH*4 = 0x1000
        doReq("stwrap", 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 0, 32'h0, 1'b0);
        doReq("ldwrap", 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h5A5A5A5A, 1'b0);
        doReq("ldhigh", 1'b0, 32'hFFFF_F000, 32'h0, 4'h0, 0, 32'h5A5A5A5A, 1'b0);

        // Misaligned requests
        doReq("ld13", 1'b0, 32'h13, 32'h0, 4'h0, 0, ALIGN ? 32'h0 : 32'hDEADBEEF, ALIGN);
        doReq("st12", 1'b1, 32'h12, 32'hCAFEF00D, 4'hF, 0, 32'h0, ALIGN);
        doReq("ld10m", 1'b0, 32'h10, 32'h0, 4'h0, 0, ALIGN ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0);

        // Reset during WAIT after an accepted store
        issue(1'b1, 32'h30, 32'h77777777, 4'hF);
        chk("mid_state_wait", {30'd0, dbgState}, 32'd1);
        #2 reset = 1'b0;
        #1 chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_req_ready", {31'd0, req_ready}, 32'd0);
        chk("mid_rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        chk("mid_ready_after", {31'd0, req_ready}, 32'd1);
        doReq("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 0, 32'h77777777, 1'b0);
        doReq("ld10r", 1'b0, 32'h10, 32'h0, 4'h0, 0, ALIGN ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, giving the number of 32-bit words; legal values are powers of two from 16 to 65536.
REQ-002 SHALL have parameter LATENCY, default 2, giving the cycles from request acceptance to response valid; legal values are 1 to 15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the memory stage presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 SHALL have port req_be, input, 4 bits: byte enables for a store, bit i enabling byte lane i.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the requester accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: load data; 0 for stores.
REQ-014 SHALL have port rsp_err, output, 1 bit: the request was rejected as misaligned.

Function
REQ-015 SHALL implement a three-state machine: IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE and SHALL NOT combinationally depend on req_valid.
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, then move IDLE->WAIT, or IDLE->RESP when LATENCY=1.
REQ-018 SHALL, at acceptance, load a down-counter with LATENCY-1; in WAIT it decrements each cycle and moves to RESP on the edge where it reads 1.
REQ-019 SHALL assert rsp_valid exactly LATENCY cycles after the acceptance edge and hold it, with rsp_rdata and rsp_err stable, until rsp_valid and rsp_ready are both 1.
REQ-020 SHALL, on response handshake, return to IDLE; the next request can be accepted on the following edge at the earliest, so peak throughput is one request per LATENCY+1 cycles.
REQ-021 SHALL ignore rsp_ready outside RESP and ignore req_* outside IDLE.
REQ-022 SHALL form the word index as req_addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-023 SHALL perform a store at the acceptance edge, writing only the byte lanes enabled in req_be; req_be=0 is a legal no-op that still returns a response.
REQ-024 SHALL capture load data at the acceptance edge, so a load returns memory contents as of acceptance.
REQ-025 SHALL return rsp_rdata=0 and rsp_err=0 for a store.

Reset
REQ-026 SHALL, while reset=0, force state IDLE, counter 0, req_ready=0 (it rises after reset deasserts), rsp_valid=0, rsp_rdata=0 and rsp_err=0, independent of clk.
REQ-027 SHALL NOT reset the memory array; its contents are undefined after power-up and preserved across reset.
REQ-028 SHALL, when reset asserts mid-transaction, abandon the transaction with no response; a store already accepted remains written.

Configuration
REQ-029 SHALL compile alignment checking in when macro DMEM_ALIGN_CHECK_EN is defined: a request with req_addr[1:0]!=0 performs no memory access and responds with rsp_err=1 and rsp_rdata=0, after the same latency.
REQ-030 SHALL, when DMEM_ALIGN_CHECK_EN is undefined, ignore req_addr[1:0] and tie rsp_err to 0.

Verification
REQ-031 SHALL verify store then load with LATENCY=2: store 0xDEADBEEF at 0x10 with be=0xF, then load 0x10 -> rsp_valid asserted 2 cycles after each acceptance; load returns 0xDEADBEEF with rsp_err=0.
REQ-032 SHALL verify byte-lane merge: word at 0x20 holds 0x11223344; store 0x000000AA at 0x20 with be=0x1 -> a load of 0x20 returns 0x112233AA.
REQ-033 SHALL verify backpressure: hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; req_ready=1 the cycle after the handshake.
REQ-034 SHALL verify wrap-around with DEPTH=1024: store 0x5A5A5A5A at 0x1000 -> a load of 0x0 returns 0x5A5A5A5A.
REQ-035 SHALL verify misalignment with DMEM_ALIGN_CHECK_EN defined: load at 0x13 -> rsp_err=1 and rsp_rdata=0; a store at 0x12 leaves word 0x10 unchanged.
REQ-036 SHALL verify mid-transaction reset: pull reset low in WAIT -> rsp_valid=0 immediately, and after release no response is issued and req_ready=1.
